// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: N-way round-robin bus arbiter with grant hold (bus lock).
// A requester keeps the bus while it keeps requesting. If MAX_HOLD is
// nonzero, the hold is bounded whenever other masters are waiting.
// Grant, grant_id and grant_valid are registered together, so grant can
// drive the bus mux select directly.
// Optional feature: define RR_ARB_MASK_EN to add the req_mask input.
// Effective request = req & ~req_mask.
module rr_arbiter_hold #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
`ifdef RR_ARB_MASK_EN
    input  logic [N-1:0]   req_mask,
`endif
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           hold_expired
);

    // Hold counter is wide enough to reach MAX_HOLD. For unlimited hold it
    // only needs to saturate, so a single bit is enough.
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? CW'(MAX_HOLD) : {CW{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           grant_valid_q, grant_valid_d;
    logic           hold_expired_q, hold_expired_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;

    logic [N-1:0]   req_eff;
    logic [N-1:0]   arb_req;
    logic           owner_req;
    logic           others_req;
    logic           keep;
    logic           win_found;
    logic [IDW-1:0] win_idx;

`ifdef RR_ARB_MASK_EN
    assign req_eff = req & ~req_mask;
`else
    assign req_eff = req;
`endif

    assign owner_req  = |(req_eff & grant_q);
    assign others_req = |(req_eff & ~grant_q);

    // The current owner never takes part in arbitration.
    // - On release its request bit is already low.
    // - On expiry it must lose even though it is still requesting.
    // - In IDLE grant_q is zero, so the whole request vector competes.
    assign arb_req = req_eff & ~grant_q;

    // Find the first request at or after the pointer, wrapping modulo N.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!win_found && arb_req[IDW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    // Decide the next state: keep the owner, hand over, or go idle.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        grant_id_d     = grant_id_q;
        grant_valid_d  = grant_valid_q;
        hold_expired_d = 1'b0;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;

        keep = (state_q == OWNED) && owner_req &&
               ((MAX_HOLD == 0) || (hold_cnt_q < HOLD_SAT) || !others_req);

        if (keep) begin
            if (hold_cnt_q != HOLD_SAT) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end else if (win_found) begin
            state_d          = OWNED;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            grant_id_d       = win_idx;
            grant_valid_d    = 1'b1;
            hold_cnt_d       = CW'(1);
            ptr_d            = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
            // If the owner is still requesting and loses anyway, its hold ran out.
            hold_expired_d   = (state_q == OWNED) && owner_req;
        end else begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
            hold_cnt_d    = '0;
        end
    end

    // State and output registers; reset wins over everything, including an active hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_id_q     <= '0;
            grant_valid_q  <= 1'b0;
            hold_expired_q <= 1'b0;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            grant_id_q     <= grant_id_d;
            grant_valid_q  <= grant_valid_d;
            hold_expired_q <= hold_expired_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign grant        = grant_q;
    assign grant_id     = grant_id_q;
    assign grant_valid  = grant_valid_q;
    assign hold_expired = hold_expired_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Testbench for rr_arbiter_hold.
// - u4: N=4, MAX_HOLD=3, driven from a table of per-cycle vectors.
// - u5: N=5, MAX_HOLD=0, driven by hand-written sequences.
// Mask sequences are included when RR_ARB_MASK_EN is defined.
module tb_rr_arbiter_hold;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic       rst4;
    logic [3:0] req4;
    logic [3:0] grant4;
    logic [1:0] id4;
    logic       valid4;
    logic       exp4;

    // N=5 instance
    logic       rst5;
    logic [4:0] req5;
    logic [4:0] grant5;
    logic [2:0] id5;
    logic       valid5;
    logic       exp5;

`ifdef RR_ARB_MASK_EN
    logic [3:0] mask4;
    logic [4:0] mask5;
`endif

    rr_arbiter_hold #(.N(4), .MAX_HOLD(3)) u4 (
        .clk          (clk),
        .reset        (rst4),
        .req          (req4),
`ifdef RR_ARB_MASK_EN
        .req_mask     (mask4),
`endif
        .grant        (grant4),
        .grant_id     (id4),
        .grant_valid  (valid4),
        .hold_expired (exp4)
    );

    rr_arbiter_hold #(.N(5), .MAX_HOLD(0)) u5 (
        .clk          (clk),
        .reset        (rst5),
        .req          (req5),
`ifdef RR_ARB_MASK_EN
        .req_mask     (mask5),
`endif
        .grant        (grant5),
        .grant_id     (id5),
        .grant_valid  (valid5),
        .hold_expired (exp5)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       e;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] id, input logic v, input logic e);
        vec_t t;
        t.rst = rst;
        t.req = r;
        t.g   = g;
        t.id  = id;
        t.v   = v;
        t.e   = e;
        vecs.push_back(t);
    endtask

    task automatic step5(input logic [4:0] r);
        req5 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk5(input string name, input logic [4:0] eg, input logic [2:0] eid,
                        input logic ev, input logic ee);
        total++;
        $display("n5 %s req=%b grant=%b id=%0d valid=%b exp=%b", name, req5, grant5, id5, valid5, exp5);
        if ({grant5, id5, valid5, exp5} === {eg, eid, ev, ee}) begin
            passed++;
        end else begin
            $display("FAIL %s: got grant=%b id=%0d valid=%b exp=%b, want grant=%b id=%0d valid=%b exp=%b",
                     name, grant5, id5, valid5, exp5, eg, eid, ev, ee);
        end
    endtask

    initial begin
        logic [4:0] cur_oh;
        logic [2:0] cur_id;

        rst4 = 1'b1;
        req4 = '0;
        rst5 = 1'b1;
        req5 = '0;
`ifdef RR_ARB_MASK_EN
        mask4 = '0;
        mask5 = '0;
`endif

        // Each vector: inputs applied for one clock edge, expected outputs after that edge.
        //   rst   req      grant    id  v  e
        add(1'b1, 4'b1111, 4'b0000, 0, 0, 0);  // 0: reset
        add(1'b0, 4'b1111, 4'b0001, 0, 1, 0);  // 1: first grant follows pointer 0
        add(1'b0, 4'b1111, 4'b0001, 0, 1, 0);
        add(1'b0, 4'b1111, 4'b0001, 0, 1, 0);
        add(1'b0, 4'b1111, 4'b0010, 1, 1, 1);  // 4: expiry handover
        add(1'b0, 4'b1111, 4'b0010, 1, 1, 0);
        add(1'b0, 4'b1111, 4'b0010, 1, 1, 0);
        add(1'b0, 4'b1111, 4'b0100, 2, 1, 1);
        add(1'b0, 4'b1111, 4'b0100, 2, 1, 0);
        add(1'b0, 4'b1111, 4'b0100, 2, 1, 0);
        add(1'b0, 4'b1111, 4'b1000, 3, 1, 1);
        add(1'b0, 4'b1111, 4'b1000, 3, 1, 0);
        add(1'b0, 4'b1111, 4'b1000, 3, 1, 0);
        add(1'b0, 4'b1111, 4'b0001, 0, 1, 1);  // 13: wrap back to 0
        add(1'b0, 4'b1111, 4'b0001, 0, 1, 0);
        add(1'b0, 4'b1111, 4'b0001, 0, 1, 0);
        add(1'b0, 4'b0100, 4'b0100, 2, 1, 0);  // 16: owner released, 2 wins with no expiry
        for (int i = 0; i < 10; i++) begin
            add(1'b0, 4'b0100, 4'b0100, 2, 1, 0);  // sole requester never expires
        end
        add(1'b0, 4'b0010, 4'b0010, 1, 1, 0);  // 27: owner 1, pointer now 2
        add(1'b0, 4'b0010, 4'b0010, 1, 1, 0);
        add(1'b0, 4'b1001, 4'b1000, 3, 1, 0);  // 29: 3 beats 0, no bubble
        add(1'b0, 4'b0000, 4'b0000, 0, 0, 0);  // 30: all drop -> idle
        add(1'b0, 4'b0001, 4'b0001, 0, 1, 0);  // 31: idle to grant in 1 cycle
        add(1'b0, 4'b1000, 4'b1000, 3, 1, 0);  // 32: owner 3, hold 1
        add(1'b0, 4'b1000, 4'b1000, 3, 1, 0);  // hold 2
        add(1'b1, 4'b1010, 4'b0000, 0, 0, 0);  // 34: reset mid-hold
        add(1'b0, 4'b1010, 4'b0010, 1, 1, 0);  // 35: pointer back to 0 -> 1 wins
        add(1'b0, 4'b1010, 4'b0010, 1, 1, 0);
        add(1'b0, 4'b1010, 4'b0010, 1, 1, 0);
        add(1'b0, 4'b1010, 4'b1000, 3, 1, 1);  // 38: expiry, 1 masked out
        add(1'b0, 4'b1010, 4'b1000, 3, 1, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst4 = vecs[i].rst;
            req4 = vecs[i].req;
            @(posedge clk);
            #1;
            total++;
            $display("vec %0d rst=%b req=%b grant=%b id=%0d valid=%b exp=%b",
                     i, rst4, req4, grant4, id4, valid4, exp4);
            if ({grant4, id4, valid4, exp4} === {vecs[i].g, vecs[i].id, vecs[i].v, vecs[i].e}) begin
                passed++;
            end else begin
                $display("FAIL vec%0d: got grant=%b id=%0d valid=%b exp=%b, want grant=%b id=%0d valid=%b exp=%b",
                         i, grant4, id4, valid4, exp4, vecs[i].g, vecs[i].id, vecs[i].v, vecs[i].e);
            end
        end

        // N=5, unlimited hold: owners alternate between 0 and 4 across the wrap.
        rst5 = 1'b1;
        step5(5'b10001);
        chk5("n5_reset", 5'b00000, 0, 0, 0);
        rst5 = 1'b0;
        step5(5'b10001);
        chk5("n5_first", 5'b00001, 0, 1, 0);
        step5(5'b10001);
        chk5("n5_keep0", 5'b00001, 0, 1, 0);
        cur_oh = 5'b00001;
        cur_id = 3'd0;
        for (int i = 0; i < 4; i++) begin
            step5(5'b10001 & ~cur_oh);
            if (cur_id == 3'd0) begin
                cur_oh = 5'b10000;
                cur_id = 3'd4;
            end else begin
                cur_oh = 5'b00001;
                cur_id = 3'd0;
            end
            chk5("n5_switch", cur_oh, cur_id, 1, 0);
            step5(5'b10001);
            chk5("n5_hold_a", cur_oh, cur_id, 1, 0);
            step5(5'b10001);
            chk5("n5_hold_b", cur_oh, cur_id, 1, 0);
        end
        // MAX_HOLD=0 means the owner is never pushed off, even while others wait.
        for (int i = 0; i < 10; i++) begin
            step5(5'b10001);
            chk5("n5_unlimited", cur_oh, cur_id, 1, 0);
        end

`ifdef RR_ARB_MASK_EN
        // Make 4 the owner, then mask it: it is released on the next cycle.
        step5(5'b10000);
        chk5("n5_owner4", 5'b10000, 4, 1, 0);
        mask5 = 5'b10000;
        step5(5'b10001);
        chk5("n5_mask_release", 5'b00001, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step5(5'b10001);
            chk5("n5_mask_only0", 5'b00001, 0, 1, 0);
        end
        step5(5'b10000);
        chk5("n5_mask_idle", 5'b00000, 0, 0, 0);
        mask5 = '0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
